// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters.
// Grants are packet-level and round-robin; an idle timeout revokes a stalled grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout
);
  localparam int              GW        = $clog2(NUM_REQ);
  localparam logic [15:0]     TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [GW-1:0]   LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [GW-1:0] grant_r, grant_nxt_s;
  logic [GW-1:0] last_grant_r, last_grant_nxt_s;
  logic [15:0]   cnt_r, cnt_nxt_s;
  logic          timeout_r, timeout_nxt_s;
  logic [GW-1:0] sel_s;
  int            best_dist_s;
  logic          any_req_s;
  logic          g_valid_s, g_last_s;
  logic [7:0]    g_data_s;

  // Fields of the currently granted requester
  assign g_valid_s = req_valid[grant_r];
  assign g_last_s  = req_last[grant_r];
  assign g_data_s  = req_data[{grant_r, 3'b000} +: 8];
  assign any_req_s = |req_valid;

  assign busy     = (state_r == XFER);
  assign grant_id = grant_r;
  assign timeout  = timeout_r;

  // Round-robin pick: the valid requester closest above last_grant wins
  always_comb begin
    sel_s       = {GW{1'b0}};
    best_dist_s = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (((i + NUM_REQ - 1 - int'(last_grant_r)) % NUM_REQ) < best_dist_s)) begin
        best_dist_s = (i + NUM_REQ - 1 - int'(last_grant_r)) % NUM_REQ;
        sel_s       = GW'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Byte path to the UART and acceptance back to the granted requester
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    if (state_r == XFER) begin
      tx_valid  = g_valid_s;
      tx_data   = g_data_s;
      req_ready = {{(NUM_REQ-1){1'b0}}, tx_ready} << grant_r;
    end else begin
      tx_valid  = 1'b0;
    end
  end

  // Next-state: grant on request, release on last byte or idle timeout
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    cnt_nxt_s        = cnt_r;
    timeout_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = XFER;
          grant_nxt_s = sel_s;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s   = 16'd0;
        end
      end
      XFER: begin
        if (g_valid_s && tx_ready) begin
          // a transfer always beats an expiring counter
          cnt_nxt_s = 16'd0;
          if (g_last_s) begin
            state_nxt_s      = IDLE;
            last_grant_nxt_s = grant_r;
          end else begin
            state_nxt_s      = XFER;
          end
        end else if (!g_valid_s) begin
          if (cnt_r == TO_LAST) begin
            state_nxt_s      = IDLE;
            last_grant_nxt_s = grant_r;
            cnt_nxt_s        = 16'd0;
            timeout_nxt_s    = 1'b1;
          end else begin
            cnt_nxt_s        = cnt_r + 16'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= LAST_INIT;
      cnt_r        <= 16'd0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      cnt_r        <= cnt_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level model compared every cycle,
// plus directed scenarios with hand-computed transfer logs and timing.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 1024;
  localparam int GW      = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]         q_data [NUM_REQ][$];
  logic               q_last [NUM_REQ][$];
  logic [NUM_REQ-1:0] hold_off = '0;
  logic [NUM_REQ-1:0] acc_r    = '0;

  int log_id[$];
  int log_data[$];
  int log_cyc[$];
  int to_cyc[$];

  // packet-level model state: owner of the transmitter (-1 = nobody)
  int m_owner  = -1;
  int m_last   = NUM_REQ - 1;
  int m_silent = 0;
  int m_grant  = 0;
  bit m_pulse  = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [NUM_REQ-1:0] v, input int i);
    return v[i[GW-1:0]];
  endfunction

  function automatic logic [7:0] byte_at(input logic [NUM_REQ*8-1:0] v, input int i);
    return v[{i[GW-1:0], 3'b000} +: 8];
  endfunction

  function automatic int pick_next(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++)
      if (bit_at(v, (last + k) % NUM_REQ)) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int at_q(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Model: a grant lasts until a last byte moves or TIMEOUT consecutive silent cycles pass
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_last <= NUM_REQ - 1; m_silent <= 0; m_grant <= 0; m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (m_owner < 0) begin
        if (pick_next(m_last, req_valid) >= 0) begin
          m_owner  <= pick_next(m_last, req_valid);
          m_grant  <= pick_next(m_last, req_valid);
          m_silent <= 0;
        end
      end else if (bit_at(req_valid, m_owner) && tx_ready) begin
        m_silent <= 0;
        if (bit_at(req_last, m_owner)) begin
          m_owner <= -1; m_last <= m_owner;
        end
      end else if (!bit_at(req_valid, m_owner)) begin
        if (m_silent + 1 == TIMEOUT) begin
          m_owner <= -1; m_last <= m_owner; m_silent <= 0; m_pulse <= 1'b1;
        end else begin
          m_silent <= m_silent + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic present();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i] = !hold_off[i];
        req_data[8*i +: 8] = q_data[i][0];
        req_last[i] = q_last[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    q_data[i].push_back(d);
    q_last[i].push_back(l);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (q_data[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((pending() || busy) && n < budget) begin tick(); n++; end
    chk(name, int'(n < budget), 1);
  endtask

  task automatic wait_log(input string name, input int base);
    int n = 0;
    while (log_id.size() == base && n < 50) begin @(negedge clk); #1; n++; end
    chk(name, int'(log_id.size() > base), 1);
  endtask

  // Requesters: drop the accepted byte and present the next one
  task automatic driver_loop();
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_r[i] && q_data[i].size() > 0) begin
          void'(q_data[i].pop_front());
          void'(q_last[i].pop_front());
        end
      end
      present();
    end
  endtask

  // Per-cycle compare of every output against the model, plus transfer/timeout logging
  task automatic monitor_loop();
    logic               exp_busy, exp_txv;
    logic [7:0]         exp_txd;
    logic [NUM_REQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      acc_r = req_valid & req_ready;
      if (tx_valid && tx_ready) begin
        log_id.push_back(int'(grant_id));
        log_data.push_back(int'(tx_data));
        log_cyc.push_back(cyc);
      end
      if (timeout) to_cyc.push_back(cyc);
      exp_busy = (m_owner >= 0);
      exp_txv  = exp_busy && bit_at(req_valid, m_owner);
      exp_txd  = exp_busy ? byte_at(req_data, m_owner) : 8'h00;
      exp_rdy  = (exp_busy && tx_ready) ? (NUM_REQ'(1) << m_owner) : '0;
      chk("cyc_busy", busy, exp_busy);
      chk("cyc_grant_id", grant_id, m_grant);
      chk("cyc_tx_valid", tx_valid, exp_txv);
      chk("cyc_tx_data", tx_data, exp_txd);
      chk("cyc_req_ready", req_ready, exp_rdy);
      chk("cyc_timeout", timeout, m_pulse);
    end
  endtask

  initial begin
    int base, base2, to_base;
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    fork
      monitor_loop();
      driver_loop();
    join_none

    // reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick();

    // four simultaneous single-byte packets: round-robin 0..3, one idle cycle between
    base = log_id.size();
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    present();
    wait_done("t1_done", 200);
    repeat (2) tick();
    for (int i = 0; i < NUM_REQ; i++) begin
      chk("t1_id", at_q(log_id, base + i), i);
      chk("t1_data", at_q(log_data, base + i), 160 + i);
    end
    for (int i = 1; i < NUM_REQ; i++)
      chk("t1_spacing", at_q(log_cyc, base + i) - at_q(log_cyc, base + i - 1), 2);
    chk("t1_model_last", m_last, 3);

    // 3-byte packet from 2 stays contiguous while 0 waits
    base = log_id.size();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    present();
    tick();
    push(0, 8'h0F, 1'b1);
    present();
    wait_done("t2_done", 100);
    repeat (2) tick();
    chk("t2_id0", at_q(log_id, base), 2);
    chk("t2_id1", at_q(log_id, base + 1), 2);
    chk("t2_id2", at_q(log_id, base + 2), 2);
    chk("t2_id3", at_q(log_id, base + 3), 0);
    chk("t2_data0", at_q(log_data, base), 65);
    chk("t2_data2", at_q(log_data, base + 2), 67);
    chk("t2_data3", at_q(log_data, base + 3), 15);
    chk("t2_contig", at_q(log_cyc, base + 2) - at_q(log_cyc, base), 2);

    // long UART backpressure never times out
    base = log_id.size(); to_base = to_cyc.size();
    tx_ready = 1'b0;
    push(1, 8'h5A, 1'b1);
    present();
    repeat (5000) tick();
    chk("t3_stalled_busy", busy, 1);
    chk("t3_stalled_no_xfer", log_id.size() - base, 0);
    tx_ready = 1'b1;
    wait_done("t3_done", 20);
    repeat (2) tick();
    chk("t3_id", at_q(log_id, base), 1);
    chk("t3_data", at_q(log_data, base), 90);
    chk("t3_no_timeout", to_cyc.size() - to_base, 0);

    // stalled packet: timeout edge comes TIMEOUT edges after the transfer edge
    base = log_id.size(); to_base = to_cyc.size();
    push(3, 8'h33, 1'b0);
    present();
    wait_done("t4_done", TIMEOUT + 20);
    repeat (2) tick();
    chk("t4_id", at_q(log_id, base), 3);
    chk("t4_data", at_q(log_data, base), 51);
    chk("t4_pulses", to_cyc.size() - to_base, 1);
    chk("t4_delay", at_q(to_cyc, to_base) - at_q(log_cyc, base), TIMEOUT + 1);
    chk("t4_model_last", m_last, 3);

    // valid returns exactly on the expiry cycle: transfer wins, no pulse
    base = log_id.size(); to_base = to_cyc.size();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b1);
    present();
    wait_log("t5_first", base);
    hold_off[1] = 1'b1;
    repeat (TIMEOUT) @(posedge clk);
    #2;
    hold_off[1] = 1'b0;
    present();
    wait_done("t5_done", 20);
    repeat (2) tick();
    chk("t5_id1", at_q(log_id, base + 1), 1);
    chk("t5_data0", at_q(log_data, base), 81);
    chk("t5_data1", at_q(log_data, base + 1), 82);
    chk("t5_gap", at_q(log_cyc, base + 1) - at_q(log_cyc, base), TIMEOUT);
    chk("t5_no_timeout", to_cyc.size() - to_base, 0);
    chk("t5_model_last", m_last, 1);

    // reset during byte 2 of a 4-byte packet
    base = log_id.size();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b0); push(1, 8'h64, 1'b1);
    present();
    wait_log("t6_first", base);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_timeout", timeout, 0);
    q_data[1].delete(); q_last[1].delete();
    push(0, 8'h70, 1'b1); push(2, 8'h72, 1'b1);
    present();
    #1;
    rst = 1'b0;
    base2 = log_id.size();
    wait_done("t6_done", 50);
    repeat (2) tick();
    chk("t6_before_rst", base2 - base, 1);
    chk("t6_after_count", log_id.size() - base2, 2);
    chk("t6_id0", at_q(log_id, base2), 0);
    chk("t6_data0", at_q(log_data, base2), 112);
    chk("t6_id1", at_q(log_id, base2 + 1), 2);
    chk("t6_data1", at_q(log_data, base2 + 1), 114);
    chk("t6_model_last", m_last, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
